// File: rtl/mem_access_initiator_pkg.sv
// Shared main-memory port types, access sizes, initiator states and lane-select helpers.
// Latency: none (types and pure functions only).
// Backpressure: n/a; the wait_for_mem field of PortOut_MainMem carries the memory stall.
package mem_access_initiator_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 32;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  // Encoding 3 is illegal and rejected at accept time.
  typedef enum logic [1:0] {
    Sz32 = 2'd0,
    Sz16 = 2'd1,
    Sz8  = 2'd2
  } MemAccessSize;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    RMW_READ,
    RMW_MERGE,
    WRITE,
    DONE
  } StateMemInit;

  typedef struct packed {
    logic                   req_mem_access;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   data;
    DataInoutAccessType     data_inout_access_type;
  } PortIn_MainMem;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic                   wait_for_mem;
  } PortOut_MainMem;

  localparam logic [31:0] LaneMask8  = 32'h0000_00ff;
  localparam logic [31:0] LaneMask16 = 32'h0000_ffff;
  localparam logic [31:0] LaneMask32 = 32'hffff_ffff;

  // Right-justified lane mask for an access size.
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      Sz8:     lane_mask = LaneMask8;
      Sz16:    lane_mask = LaneMask16;
      default: lane_mask = LaneMask32;
    endcase
  endfunction

  // Big-endian lane position: byte offset 0 is the most significant byte,
  // so a byte sits (3 - offset) * 8 bits up and a halfword at 16 or 0.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      Sz8:     lane_shift = {~offset, 3'b000};
      Sz16:    lane_shift = offset[1] ? 5'd0 : 5'd16;
      default: lane_shift = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_initiator_lane.sv
// Big-endian lane unit: extracts a zero-extended load value and builds the merged store word.
// Latency: combinational.
// Backpressure: none; the merge output exists only with OPT_MEM_SUBWORD_WRITE_EN defined.
module mem_lane_unit
  import mem_access_initiator_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
`ifdef OPT_MEM_SUBWORD_WRITE_EN
  input  logic [31:0] store_data,
  output logic [31:0] merged_word,
`endif
  output logic [31:0] load_data
);

  logic [4:0]  shift;
  logic [31:0] mask;

  // Shift the addressed lane down for loads and, when enabled, splice store lanes in.
  always_comb begin
    shift     = lane_shift(size, offset);
    mask      = lane_mask(size);
    load_data = (word >> shift) & mask;
`ifdef OPT_MEM_SUBWORD_WRITE_EN
    merged_word = (word & ~(mask << shift)) | ((store_data & mask) << shift);
`endif
  end

endmodule

// File: rtl/mem_access_initiator.sv
// CPU-side initiator for MainMem: one load/store at a time, sub-word loads, RMW sub-word stores.
// Latency: load 3, word store 2, sub-word store 5, error 1 cycles from accept (+1 per wait cycle).
// Backpressure: issuing states hold while in_mem.wait_for_mem; CPU requests while busy are dropped.
// Optional: OPT_MEM_SUBWORD_WRITE_EN enables the Sz16/Sz8 store read-modify-write path.
module mem_access_initiator
  import mem_access_initiator_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_cpu_req,
  input  logic           in_cpu_write,
  input  logic [1:0]     in_cpu_size,
  input  logic [31:0]    in_cpu_addr,
  input  logic [31:0]    in_cpu_data,
  output logic           out_cpu_busy,
  output logic           out_cpu_done,
  output logic           out_cpu_err,
  output logic [31:0]    out_cpu_data,
  output PortIn_MainMem  out_mem,
  input  PortOut_MainMem in_mem
);

  StateMemInit state;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wr_word;   // store data, replaced by the merged word on the RMW path
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic        reject;
`ifdef OPT_MEM_SUBWORD_WRITE_EN
  logic        write_q;
  logic [31:0] rdata_q;
  logic [31:0] merged_word;
`endif

  // Legality of the request presented in IDLE: size encoding, alignment, supported store size.
  always_comb begin
    reject = (in_cpu_size == 2'd3)
          || ((in_cpu_size == Sz16) && in_cpu_addr[0])
          || ((in_cpu_size == Sz32) && (in_cpu_addr[1:0] != 2'b00));
`ifndef OPT_MEM_SUBWORD_WRITE_EN
    reject = reject || (in_cpu_write && (in_cpu_size != Sz32));
`endif
  end

  // Loads extract from the live RAM output; the merge works on the word captured earlier.
  always_comb begin
`ifdef OPT_MEM_SUBWORD_WRITE_EN
    lane_word = (state == RMW_MERGE) ? rdata_q : in_mem.data;
`else
    lane_word = in_mem.data;
`endif
  end

  mem_lane_unit u_lane (
    .word        (lane_word),
    .offset      (addr_q[1:0]),
    .size        (size_q),
`ifdef OPT_MEM_SUBWORD_WRITE_EN
    .store_data  (wr_word),
    .merged_word (merged_word),
`endif
    .load_data   (load_data)
  );

  // Control FSM with busy/done/err/load result registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      out_cpu_busy <= 1'b0;
      out_cpu_done <= 1'b0;
      out_cpu_err  <= 1'b0;
      out_cpu_data <= '0;
      size_q       <= '0;
      addr_q       <= '0;
      wr_word      <= '0;
`ifdef OPT_MEM_SUBWORD_WRITE_EN
      write_q      <= 1'b0;
      rdata_q      <= '0;
`endif
    end else begin
      out_cpu_done <= 1'b0;
      out_cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_cpu_req) begin
            size_q       <= in_cpu_size;
            addr_q       <= in_cpu_addr;
            wr_word      <= in_cpu_data;
            out_cpu_busy <= 1'b1;
`ifdef OPT_MEM_SUBWORD_WRITE_EN
            write_q      <= in_cpu_write;
`endif
            if (reject) begin
              state        <= DONE;
              out_cpu_done <= 1'b1;
              out_cpu_err  <= 1'b1;
            end else if (!in_cpu_write) begin
              state <= READ;
            end else begin
`ifdef OPT_MEM_SUBWORD_WRITE_EN
              state <= (in_cpu_size == Sz32) ? WRITE : RMW_READ;
`else
              state <= WRITE;
`endif
            end
          end
        end
        READ: begin
          if (!in_mem.wait_for_mem) state <= CAPTURE;
        end
`ifdef OPT_MEM_SUBWORD_WRITE_EN
        RMW_READ: begin
          if (!in_mem.wait_for_mem) state <= CAPTURE;
        end
        RMW_MERGE: begin
          wr_word <= merged_word;
          state   <= WRITE;
        end
        CAPTURE: begin
          if (write_q) begin
            rdata_q <= in_mem.data;
            state   <= RMW_MERGE;
          end else begin
            out_cpu_data <= load_data;
            out_cpu_done <= 1'b1;
            state        <= DONE;
          end
        end
`else
        CAPTURE: begin
          out_cpu_data <= load_data;
          out_cpu_done <= 1'b1;
          state        <= DONE;
        end
`endif
        WRITE: begin
          if (!in_mem.wait_for_mem) begin
            out_cpu_done <= 1'b1;
            state        <= DONE;
          end
        end
        default: begin
          out_cpu_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Memory request decode; the request is gated by reset so a reset mid-WRITE never stores.
  always_comb begin
    out_mem                        = '0;
    out_mem.addr                   = {addr_q[31:2], 2'b00};
    out_mem.data                   = wr_word;
    out_mem.data_inout_access_type = (state == WRITE) ? DiatWrite : DiatRead;
`ifdef OPT_MEM_SUBWORD_WRITE_EN
    out_mem.req_mem_access = reset_n && ((state == READ) || (state == RMW_READ) || (state == WRITE));
`else
    out_mem.req_mem_access = reset_n && ((state == READ) || (state == WRITE));
`endif
  end

endmodule
